yarp_writeback: RTL and testbench

- Owns the single write port of the 32-entry integer register file.
- Arbitrates between ALU results and in-order load responses, and buffers outstanding load destination registers in a small FIFO.
- Exports per-register busy flags so decode can stall on RAW and WAW hazards.
- Sits between execute/LSU and the register file's rd_addr/wr_en/wr_data inputs.

---
 rtl/yarp_pkg.sv | 15 +
 rtl/yarp_ld_fifo.sv | 67 ++++++
 rtl/yarp_writeback.sv | 102 ++++++++++
 tb/tb_yarp_writeback.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/yarp_pkg.sv
// Shared types for the yarp writeback slice: data width, register index and
// write-port request bundle.
package yarp_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t        rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/yarp_ld_fifo.sv
// In-order FIFO of outstanding load destination registers. Every entry is
// visible with its valid bit so the writeback stage can match pending rds.
module yarp_ld_fifo
    import yarp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  reg_idx_t                 push_rd_i,
    input  logic                     pop_i,
    output reg_idx_t                 head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [DEPTH-1:0]         valid_o,
    output reg_idx_t [DEPTH-1:0]     entries_o
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [PW:0]           count_q, count_d;
    logic [DEPTH-1:0]      valid_q;
    reg_idx_t [DEPTH-1:0]  mem_q;

    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Push and pop never target the same slot: pop needs a non-empty FIFO and
    // push needs a non-full one, so equal pointers cannot see both.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push_i) begin
                wr_ptr_q          <= wr_ptr_q + 1'b1;
                valid_q[wr_ptr_q] <= 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q          <= rd_ptr_q + 1'b1;
                valid_q[rd_ptr_q] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_rd_i;
        end
    end

    assign head_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign valid_o   = valid_q;
    assign entries_o = mem_q;

endmodule

// File: rtl/yarp_writeback.sv
// Register-file write port owner: arbitrates load responses over ALU results,
// tracks outstanding load rds and reports per-source busy for hazard stalls.
module yarp_writeback
    import yarp_pkg::*;
#(
    parameter int LD_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        alu_valid_i,
    output logic                        alu_ready_o,
    input  reg_idx_t                    alu_rd_i,
    input  logic [XLEN-1:0]             alu_data_i,
    input  logic                        ld_issue_valid_i,
    output logic                        ld_issue_ready_o,
    input  reg_idx_t                    ld_issue_rd_i,
    input  logic                        ld_rsp_valid_i,
    output logic                        ld_rsp_ready_o,
    input  logic [XLEN-1:0]             ld_rsp_data_i,
    input  reg_idx_t                    rs1_addr_i,
    input  reg_idx_t                    rs2_addr_i,
    output logic                        rs1_busy_o,
    output logic                        rs2_busy_o,
    output reg_idx_t                    rd_addr_o,
    output logic                        wr_en_o,
    output logic [XLEN-1:0]             wr_data_o,
    output logic [$clog2(LD_DEPTH):0]   ld_outstanding_o
);

    localparam int CW = $clog2(LD_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(LD_DEPTH);

    reg_idx_t                 head;
    logic [CW-1:0]            count;
    logic [LD_DEPTH-1:0]      valid;
    reg_idx_t [LD_DEPTH-1:0]  entries;

    logic                     ld_acc, alu_acc, issue_acc;
    logic [LD_DEPTH-1:0]      hit_alu, hit_rs1, hit_rs2;
    logic                     pend_alu, pend_rs1, pend_rs2;

    wb_req_t                  stage_q;
    logic                     wr_en_q;

    yarp_ld_fifo #(.DEPTH(LD_DEPTH)) u_ld_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push_i    (issue_acc),
        .push_rd_i (ld_issue_rd_i),
        .pop_i     (ld_acc),
        .head_o    (head),
        .count_o   (count),
        .valid_o   (valid),
        .entries_o (entries)
    );

    for (genvar gi = 0; gi < LD_DEPTH; gi++) begin : g_match
        assign hit_alu[gi] = valid[gi] && (entries[gi] == alu_rd_i);
        assign hit_rs1[gi] = valid[gi] && (entries[gi] == rs1_addr_i);
        assign hit_rs2[gi] = valid[gi] && (entries[gi] == rs2_addr_i);
    end

    // x0 is never architecturally pending, even though loads to it occupy a slot.
    assign pend_alu = (|hit_alu) && (alu_rd_i   != '0);
    assign pend_rs1 = (|hit_rs1) && (rs1_addr_i != '0);
    assign pend_rs2 = (|hit_rs2) && (rs2_addr_i != '0);

    assign ld_rsp_ready_o   = (count != '0);
    assign ld_acc           = ld_rsp_valid_i && ld_rsp_ready_o;
    assign alu_ready_o      = !ld_acc && !pend_alu;
    assign alu_acc          = alu_valid_i && alu_ready_o;
    assign ld_issue_ready_o = (count < DEPTH_C);
    assign issue_acc        = ld_issue_valid_i && ld_issue_ready_o;
    assign ld_outstanding_o = count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_q <= '0;
            wr_en_q <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            if (ld_acc) begin
                stage_q.rd   <= head;
                stage_q.data <= ld_rsp_data_i;
                wr_en_q      <= (head != '0);
            end else if (alu_acc) begin
                stage_q.rd   <= alu_rd_i;
                stage_q.data <= alu_data_i;
                wr_en_q      <= (alu_rd_i != '0);
            end
        end
    end

    assign rd_addr_o = stage_q.rd;
    assign wr_data_o = stage_q.data;
    assign wr_en_o   = wr_en_q;

    // The staged write is still in flight until the register file captures it.
    assign rs1_busy_o = (rs1_addr_i != '0) && (pend_rs1 || (wr_en_q && stage_q.rd == rs1_addr_i));
    assign rs2_busy_o = (rs2_addr_i != '0) && (pend_rs2 || (wr_en_q && stage_q.rd == rs2_addr_i));

endmodule

// File: tb/tb_yarp_writeback.sv
// Directed plus short random bench for yarp_writeback with a write scoreboard
// and a reference queue of outstanding load rds.
module tb_yarp_writeback;
    import yarp_pkg::*;

    localparam int LD_DEPTH = 4;
    localparam int CW = $clog2(LD_DEPTH) + 1;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            alu_valid_i, alu_ready_o;
    reg_idx_t        alu_rd_i;
    logic [XLEN-1:0] alu_data_i;
    logic            ld_issue_valid_i, ld_issue_ready_o;
    reg_idx_t        ld_issue_rd_i;
    logic            ld_rsp_valid_i, ld_rsp_ready_o;
    logic [XLEN-1:0] ld_rsp_data_i;
    reg_idx_t        rs1_addr_i, rs2_addr_i;
    logic            rs1_busy_o, rs2_busy_o;
    reg_idx_t        rd_addr_o;
    logic            wr_en_o;
    logic [XLEN-1:0] wr_data_o;
    logic [CW-1:0]   ld_outstanding_o;

    always #5 clk = ~clk;

    yarp_writeback #(.LD_DEPTH(LD_DEPTH)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .alu_valid_i      (alu_valid_i),
        .alu_ready_o      (alu_ready_o),
        .alu_rd_i         (alu_rd_i),
        .alu_data_i       (alu_data_i),
        .ld_issue_valid_i (ld_issue_valid_i),
        .ld_issue_ready_o (ld_issue_ready_o),
        .ld_issue_rd_i    (ld_issue_rd_i),
        .ld_rsp_valid_i   (ld_rsp_valid_i),
        .ld_rsp_ready_o   (ld_rsp_ready_o),
        .ld_rsp_data_i    (ld_rsp_data_i),
        .rs1_addr_i       (rs1_addr_i),
        .rs2_addr_i       (rs2_addr_i),
        .rs1_busy_o       (rs1_busy_o),
        .rs2_busy_o       (rs2_busy_o),
        .rd_addr_o        (rd_addr_o),
        .wr_en_o          (wr_en_o),
        .wr_data_o        (wr_data_o),
        .ld_outstanding_o (ld_outstanding_o)
    );

    int       vectors = 0;
    int       miscompares = 0;
    reg_idx_t ldq[$];
    wb_req_t  wq[$];
    logic     stg_en = 1'b0;
    reg_idx_t stg_rd = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_pend(input reg_idx_t r);
        if (r == 0) return 1'b0;
        foreach (ldq[i]) if (ldq[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_busy(input reg_idx_t r);
        return (r != 0) && (m_pend(r) || (stg_en && stg_rd == r));
    endfunction

    task automatic drive(input logic av, input int ard, input logic [31:0] ad,
                         input logic iv, input int ird,
                         input logic rv, input logic [31:0] rdat);
        alu_valid_i      = av;
        alu_rd_i         = reg_idx_t'(ard);
        alu_data_i       = ad;
        ld_issue_valid_i = iv;
        ld_issue_rd_i    = reg_idx_t'(ird);
        ld_rsp_valid_i   = rv;
        ld_rsp_data_i    = rdat;
    endtask

    task automatic idle();
        drive(1'b0, 0, 32'h0, 1'b0, 0, 1'b0, 32'h0);
    endtask

    // One clock: check readies/busy against the model, record the expected
    // transfers, then check the write port one cycle later.
    task automatic step();
        logic    acc_ld, alu_rdy, iss_ok;
        int      sz;
        wb_req_t e;
        #1;
        sz      = ldq.size();
        acc_ld  = ld_rsp_valid_i && (sz != 0);
        alu_rdy = !acc_ld && !m_pend(alu_rd_i);
        iss_ok  = ld_issue_valid_i && (sz < LD_DEPTH);
        chk("ld_rsp_ready", 64'(ld_rsp_ready_o), 64'(sz != 0));
        chk("alu_ready", 64'(alu_ready_o), 64'(alu_rdy));
        chk("ld_issue_ready", 64'(ld_issue_ready_o), 64'(sz < LD_DEPTH));
        chk("ld_outstanding", 64'(ld_outstanding_o), 64'(sz));
        chk("rs1_busy", 64'(rs1_busy_o), 64'(m_busy(rs1_addr_i)));
        chk("rs2_busy", 64'(rs2_busy_o), 64'(m_busy(rs2_addr_i)));
        if (acc_ld) begin
            e.rd   = ldq.pop_front();
            e.data = ld_rsp_data_i;
            wq.push_back(e);
        end else if (alu_valid_i && alu_rdy) begin
            e.rd   = alu_rd_i;
            e.data = alu_data_i;
            wq.push_back(e);
        end
        if (iss_ok) ldq.push_back(ld_issue_rd_i);
        @(posedge clk);
        #1;
        if (wq.size() != 0) begin
            e      = wq.pop_front();
            stg_en = (e.rd != 0);
            stg_rd = e.rd;
            chk("wr_en", 64'(wr_en_o), 64'(stg_en));
            if (stg_en) begin
                chk("rd_addr", 64'(rd_addr_o), 64'(e.rd));
                chk("wr_data", 64'(wr_data_o), 64'(e.data));
            end
        end else begin
            stg_en = 1'b0;
            chk("wr_en_idle", 64'(wr_en_o), 64'd0);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        rs1_addr_i = 5'd5;
        rs2_addr_i = 5'd0;
        #2;
        chk("rst_wr_en", 64'(wr_en_o), 64'd0);
        chk("rst_rd_addr", 64'(rd_addr_o), 64'd0);
        chk("rst_wr_data", 64'(wr_data_o), 64'd0);
        chk("rst_count", 64'(ld_outstanding_o), 64'd0);
        chk("rst_rsp_ready", 64'(ld_rsp_ready_o), 64'd0);
        chk("rst_rs1_busy", 64'(rs1_busy_o), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // ALU write x5, one-cycle pulse
        drive(1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 1'b0, 0);
        step();
        idle();
        step();

        // Load to x7: busy while pending and while staged
        rs1_addr_i = 5'd7;
        drive(1'b0, 0, 0, 1'b1, 7, 1'b0, 0);
        step();
        idle();
        step();
        drive(1'b0, 0, 0, 1'b0, 0, 1'b1, 32'h1234);
        step();
        idle();
        step();
        step();

        // Load response beats a same-cycle ALU result
        rs2_addr_i = 5'd3;
        drive(1'b0, 0, 0, 1'b1, 9, 1'b0, 0);
        step();
        drive(1'b1, 3, 32'h3333, 1'b0, 0, 1'b1, 32'h9999);
        step();
        drive(1'b1, 3, 32'h3333, 1'b0, 0, 1'b0, 0);
        step();
        idle();
        step();

        // Fill to LD_DEPTH, full-plus-response, then drain in order
        for (int i = 0; i < LD_DEPTH; i++) begin
            drive(1'b0, 0, 0, 1'b1, 10 + i, 1'b0, 0);
            step();
        end
        drive(1'b0, 0, 0, 1'b1, 20, 1'b1, 32'hA000);
        step();
        for (int i = 1; i < LD_DEPTH; i++) begin
            drive(1'b0, 0, 0, 1'b0, 0, 1'b1, 32'hA000 + i);
            step();
        end
        idle();
        step();

        // WAW: ALU to x7 held off by pending load to x7
        drive(1'b0, 0, 0, 1'b1, 7, 1'b0, 0);
        step();
        drive(1'b1, 7, 32'h7777, 1'b0, 0, 1'b0, 0);
        step();
        step();
        drive(1'b1, 7, 32'h7777, 1'b0, 0, 1'b1, 32'h0707);
        step();
        drive(1'b1, 7, 32'h7777, 1'b0, 0, 1'b0, 0);
        step();
        idle();
        step();

        // x0: ALU and load writes complete without a write pulse
        rs1_addr_i = 5'd0;
        drive(1'b1, 0, 32'hFFFF, 1'b1, 0, 1'b0, 0);
        step();
        drive(1'b0, 0, 0, 1'b0, 0, 1'b1, 32'hEEEE);
        step();
        idle();
        step();

        // Reset with loads outstanding and a staged write
        rs1_addr_i = 5'd4;
        drive(1'b0, 0, 0, 1'b1, 4, 1'b0, 0);
        step();
        drive(1'b1, 8, 32'h8888, 1'b1, 6, 1'b0, 0);
        step();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_count", 64'(ld_outstanding_o), 64'd0);
        chk("mid_rst_rsp_ready", 64'(ld_rsp_ready_o), 64'd0);
        chk("mid_rst_wr_en", 64'(wr_en_o), 64'd0);
        chk("mid_rst_rs1_busy", 64'(rs1_busy_o), 64'd0);
        ldq.delete();
        wq.delete();
        stg_en = 1'b0;
        idle();
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // Random mixed traffic on a small register range to provoke hazards
        for (int n = 0; n < 300; n++) begin
            drive(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom,
                  1'($urandom_range(0, 1)), $urandom_range(0, 7),
                  1'($urandom_range(0, 1)), $urandom);
            rs1_addr_i = reg_idx_t'($urandom_range(0, 7));
            rs2_addr_i = reg_idx_t'($urandom_range(0, 7));
            step();
        end
        for (int n = 0; n < LD_DEPTH + 2; n++) begin
            drive(1'b0, 0, 0, 1'b0, 0, 1'b1, $urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
